// File: rtl/router_pkt_tx_pkg.sv
// rtl/router_pkt_tx_pkg.sv - shared router constants, header fields and tx state encoding
package router_pkt_tx_pkg;

  localparam int ADDR_W      = 2;
  localparam int LEN_W       = 6;
  localparam int MAX_PAYLOAD = 63;
  localparam logic [ADDR_W-1:0] DEST_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } state_t;

  function automatic logic [7:0] make_header(input logic [LEN_W-1:0] l, input logic [ADDR_W-1:0] d);
    return {l, d};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - 64x8 payload buffer, one write port, registered write-first read port
module router_tx_buf
  import router_pkt_tx_pkg::*;
(
  input  logic       clock,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [0:MAX_PAYLOAD];

  // Write-first so a single-byte packet sees its byte on the edge that enters HEADER.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
    else                               rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - packet transmitter: collect payload, send header/payload/parity to router.
// Optional ROUTER_TX_PARITY_INJ_EN adds inj_err to emit inverted parity for the request.
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  output logic       ready,
  output logic       req_err,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       done
`ifdef ROUTER_TX_PARITY_INJ_EN
  ,
  input  logic       inj_err
`endif
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [ADDR_W-1:0] dest_q;
  logic [3:0]        gap_q;
  logic [7:0]        parity_q;
  logic              inj_q, inj_in;
  logic [5:0]        rd_addr;
  logic [7:0]        rd_data;
  logic              req_ok, accept, last_acc, step;

`ifdef ROUTER_TX_PARITY_INJ_EN
  assign inj_in = inj_err;
`else
  assign inj_in = 1'b0;
`endif

  assign ready    = (state_q == IDLE);
  assign pl_ready = (state_q == COLLECT);
  assign req_ok   = start && (dest != DEST_INVALID) && (len != '0);
  assign accept   = pl_valid && (state_q == COLLECT);
  assign last_acc = accept && (cnt_q == len_q - 6'd1);
  assign step     = !busy;

  router_tx_buf u_buf (
    .clock   (clock),
    .wr_en   (accept),
    .wr_addr (cnt_q),
    .wr_data (pl_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // rd_data always holds payload byte cnt_q; on an advance the read pointer looks one ahead.
  always_comb begin
    state_d = state_q;
    rd_addr = cnt_q;
    case (state_q)
      IDLE:    if (req_ok) state_d = COLLECT;
      COLLECT: begin
        rd_addr = '0;
        if (last_acc) state_d = HEADER;
      end
      HEADER:  if (step) begin
        state_d = PAYLOAD;
        rd_addr = cnt_q + 6'd1;
      end
      PAYLOAD: if (step) begin
        if (cnt_q == len_q) state_d = PARITY;
        else                rd_addr = cnt_q + 6'd1;
      end
      PARITY:  if (step) state_d = GAP;
      GAP:     if (gap_q == 4'(GAP_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      len_q     <= '0;
      dest_q    <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      parity_q  <= '0;
      inj_q     <= 1'b0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      done      <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_err <= 1'b0;
      done    <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          if (req_ok) begin
            len_q    <= len;
            dest_q   <= dest;
            cnt_q    <= '0;
            parity_q <= make_header(len, dest);
            inj_q    <= inj_in;
          end else begin
            req_err  <= 1'b1;
          end
        end
        COLLECT: if (accept) begin
          parity_q <= parity_q ^ pl_data;
          cnt_q    <= cnt_q + 6'd1;
          if (last_acc) begin
            cnt_q     <= '0;
            data_out  <= make_header(len_q, dest_q);
            pkt_valid <= 1'b1;
          end
        end
        HEADER: if (step) begin
          data_out <= rd_data;
          cnt_q    <= cnt_q + 6'd1;
        end
        PAYLOAD: if (step) begin
          if (cnt_q == len_q) begin
            pkt_valid <= 1'b0;
            data_out  <= inj_q ? ~parity_q : parity_q;
          end else begin
            data_out  <= rd_data;
            cnt_q     <= cnt_q + 6'd1;
          end
        end
        PARITY: if (step) begin
          done     <= 1'b1;
          data_out <= '0;
          gap_q    <= '0;
        end
        GAP:     gap_q <= gap_q + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - randomized self-checking bench for router_pkt_tx against a packet-level model
module tb_router_pkt_tx;

  localparam int GAP = 2;
`ifdef ROUTER_TX_PARITY_INJ_EN
  localparam bit INJ_BUILD = 1'b1;
`else
  localparam bit INJ_BUILD = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn, start, pl_valid, busy;
  logic [1:0] dest;
  logic [5:0] len;
  logic [7:0] pl_data, data_out;
  logic       ready, req_err, pl_ready, pkt_valid, done;
`ifdef ROUTER_TX_PARITY_INJ_EN
  logic       inj_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] pl_mem [64];

  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .dest      (dest),
    .len       (len),
    .ready     (ready),
    .req_err   (req_err),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .done      (done)
`ifdef ROUTER_TX_PARITY_INJ_EN
    ,
    .inj_err   (inj_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    chk("wait_ready", ready, 1);
  endtask

  task automatic issue(input int d, input int l, input bit inj);
    wait_ready();
    start = 1'b1;
    dest  = 2'(d);
    len   = 6'(l);
`ifdef ROUTER_TX_PARITY_INJ_EN
    inj_err = inj;
`endif
    tick();
    start = 1'b0;
  endtask

  task automatic run_pkt(input int d, input int l, input int busy_pct, input int valid_pct,
                         input bit inj, input int stall_at);
    logic [7:0] exp_q [$];
    logic [7:0] par;
    int acc, sent, n, g, stall_left;
    bit rdy, b;
    par = 8'(l * 4 + d);
    exp_q.push_back(par);
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(pl_mem[i]);
      par = par ^ pl_mem[i];
    end
    exp_q.push_back((inj && INJ_BUILD) ? ~par : par);

    issue(d, l, inj);
    acc = 0;
    n   = 0;
    while (acc < l && n < 2000) begin
      rdy      = pl_ready;
      pl_valid = ($urandom_range(99) < valid_pct);
      pl_data  = pl_mem[acc];
      tick();
      n++;
      if (pl_valid && rdy) acc++;
      if (acc < l) chk("early_tx", pkt_valid, 0);
    end
    chk("collected", acc, l);

    sent = 0;
    n = 0;
    stall_left = 4;
    while (sent < l + 2 && n < 2000) begin
      if (sent < l + 1) begin
        chk("pkt_valid", pkt_valid, 1);
        chk("byte", data_out, exp_q[sent]);
      end else begin
        chk("par_valid", pkt_valid, 0);
        chk("parity", data_out, exp_q[sent]);
      end
      if (sent == stall_at && stall_left > 0) begin
        b = 1'b1;
        stall_left--;
      end else begin
        b = ($urandom_range(99) < busy_pct);
      end
      busy     = b;
      pl_valid = $urandom_range(1);
      tick();
      n++;
      if (!b) sent++;
    end
    busy     = 1'b0;
    pl_valid = 1'b0;
    chk("done", done, 1);
    chk("gap_data", data_out, 0);
    chk("gap_valid", pkt_valid, 0);
    g = 0;
    while (!ready && g < 40) begin
      tick();
      g++;
      chk("done_pulse", done, 0);
    end
    chk("gap_len", g, GAP);
  endtask

  task automatic run_rej(input int d, input int l);
    issue(d, l, 1'b0);
    chk("rej_err", req_err, 1);
    chk("rej_ready", ready, 1);
    chk("rej_valid", pkt_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rej_err_off", req_err, 0);
      chk("rej_idle", ready, 1);
      chk("rej_quiet", pkt_valid, 0);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; dest = '0; len = '0;
    pl_data = '0; pl_valid = 1'b0; busy = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
    inj_err = 1'b0;
`endif
    tick();
    tick();
    chk("rst_ready", ready, 1);
    chk("rst_valid", pkt_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_plready", pl_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", req_err, 0);
    resetn = 1'b1;
    tick();

    pl_mem[0] = 8'hA1; pl_mem[1] = 8'hB2; pl_mem[2] = 8'hC3;
    run_pkt(1, 3, 0, 100, 1'b0, -1);
    run_pkt(1, 3, 0, 100, 1'b0, 2);
    run_rej(3, 5);
    run_rej(1, 0);

    for (int i = 0; i < 63; i++) pl_mem[i] = 8'($urandom);
    run_pkt(2, 63, 0, 50, 1'b0, -1);

    // abandon a packet mid-payload with an asynchronous reset
    for (int i = 0; i < 8; i++) pl_mem[i] = 8'($urandom);
    issue(0, 8, 1'b0);
    pl_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pl_data = pl_mem[i];
      tick();
    end
    pl_valid = 1'b0;
    tick();
    tick();
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", pkt_valid, 0);
    chk("arst_data", data_out, 0);
    chk("arst_ready", ready, 1);
    chk("arst_done", done, 0);
    chk("arst_plready", pl_ready, 0);
    @(posedge clock);
    #1 resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("post_rst_valid", pkt_valid, 0);
      chk("post_rst_done", done, 0);
    end
    run_pkt(0, 8, 20, 80, 1'b0, -1);

`ifdef ROUTER_TX_PARITY_INJ_EN
    pl_mem[0] = 8'hA1; pl_mem[1] = 8'hB2; pl_mem[2] = 8'hC3;
    run_pkt(1, 3, 0, 100, 1'b1, -1);
`endif

    for (int k = 0; k < 6; k++) begin
      int d, l;
      d = $urandom_range(2);
      l = $urandom_range(63, 1);
      for (int i = 0; i < l; i++) pl_mem[i] = 8'($urandom);
      run_pkt(d, l, 30, 70, 1'($urandom_range(1)), -1);
      if (k == 2) run_rej(3, $urandom_range(63));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
